// File: rtl/drawer_pkg.sv
// rtl/drawer_pkg.sv - shared drawer FSM encodings and bus-width constants
package drawer_pkg;

  localparam int BUS_COORD_W = 8;
  localparam int BUS_ADDR_W  = 16;
  localparam int BUS_RGB_W   = 24;

  localparam logic [23:0] DEFAULT_KEY_RGB = 24'hFF00FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } blit_state_t;

endpackage

// File: rtl/tile_blitter_if.sv
// rtl/tile_blitter_if.sv - draw request, ROM read data and status handshake
interface tile_blitter_if import drawer_pkg::*; #(
  parameter int COORD_W = BUS_COORD_W,
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int RGB_W   = BUS_RGB_W
);
  logic               draw;
  logic [ADDR_W-1:0]  tile_address;
  logic [COORD_W-1:0] origin_x;
  logic [COORD_W-1:0] origin_y;
  logic [RGB_W-1:0]   rom_request_data;
  logic               active;
  logic               done;

  modport master (
    output draw, tile_address, origin_x, origin_y, rom_request_data,
    input  active, done
  );

  modport slave (
    input  draw, tile_address, origin_x, origin_y, rom_request_data,
    output active, done
  );
endinterface

// File: rtl/tile_blitter_pixel_pipe.sv
// rtl/tile_blitter_pixel_pipe.sv - blit_pixel_pipe: ROM-latency-aligned
// {valid, x, y, clipped} shift register plus the registered VGA output stage
module blit_pixel_pipe import drawer_pkg::*; #(
  parameter int COORD_W  = BUS_COORD_W,
  parameter int RGB_W    = BUS_RGB_W,
  parameter int LATENCY  = 1,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter bit TRANSPARENT_EN = 1'b0,
  parameter logic [RGB_W-1:0] KEY_RGB = RGB_W'(DEFAULT_KEY_RGB)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [COORD_W:0]   in_x,
  input  logic [COORD_W:0]   in_y,
  input  logic [RGB_W-1:0]   rom_data,
  output logic               draw_enable,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [RGB_W-1:0]   rgb
);
  localparam logic [COORD_W:0] LIMIT_X = (COORD_W + 1)'(SCREEN_W);
  localparam logic [COORD_W:0] LIMIT_Y = (COORD_W + 1)'(SCREEN_H);

  logic               in_clipped;
  logic               key_hit;
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_clip;
  logic [COORD_W-1:0] pipe_x [LATENCY];
  logic [COORD_W-1:0] pipe_y [LATENCY];

  // the extra coordinate bit catches origin+offset overflowing the bus width
  assign in_clipped = in_x[COORD_W] | in_y[COORD_W] |
                      (in_x >= LIMIT_X) | (in_y >= LIMIT_Y);
  assign key_hit    = TRANSPARENT_EN && (rom_data == KEY_RGB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid  <= '0;
      pipe_clip   <= '0;
      draw_enable <= 1'b0;
      x           <= '0;
      y           <= '0;
      rgb         <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_x[k] <= '0;
        pipe_y[k] <= '0;
      end
    end else begin
      pipe_valid[0] <= in_valid;
      pipe_clip[0]  <= in_clipped;
      pipe_x[0]     <= in_x[COORD_W-1:0];
      pipe_y[0]     <= in_y[COORD_W-1:0];
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_clip[k]  <= pipe_clip[k-1];
        pipe_x[k]     <= pipe_x[k-1];
        pipe_y[k]     <= pipe_y[k-1];
      end
      draw_enable <= pipe_valid[LATENCY-1] & ~pipe_clip[LATENCY-1] & ~key_hit;
      if (pipe_valid[LATENCY-1]) begin
        x   <= pipe_x[LATENCY-1];
        y   <= pipe_y[LATENCY-1];
        rgb <= rom_data;
      end
    end
  end
endmodule

// File: rtl/tile_blitter.sv
// rtl/tile_blitter.sv - copies an IMG_W x IMG_H ROM image to (origin_x, origin_y)
// on the shared VGA plane, releasing the tri-state buses whenever idle
module tile_blitter import drawer_pkg::*; #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COORD_W  = BUS_COORD_W,
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int RGB_W    = BUS_RGB_W,
  parameter int ROM_LATENCY = 1,
  parameter bit TRANSPARENT_EN = 1'b0,
  parameter logic [RGB_W-1:0] KEY_RGB = RGB_W'(DEFAULT_KEY_RGB)
) (
  input  logic clk,
  input  logic reset,
  tile_blitter_if.slave cmd,
  output tri [ADDR_W-1:0]  rom_address_bus,
  output tri               vga_draw_enable_bus,
  output tri [COORD_W-1:0] vga_x_out_bus,
  output tri [COORD_W-1:0] vga_y_out_bus,
  output tri [RGB_W-1:0]   vga_RGB_out_bus
);
  localparam int LX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LY_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DC_W = $clog2(ROM_LATENCY + 2);
  localparam logic [LX_W-1:0] LX_LAST    = LX_W'(IMG_W - 1);
  localparam logic [LY_W-1:0] LY_LAST    = LY_W'(IMG_H - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(ROM_LATENCY);

  blit_state_t        state;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COORD_W-1:0] ox;
  logic [COORD_W-1:0] oy;
  logic [LX_W-1:0]    lx;
  logic [LY_W-1:0]    ly;
  logic [DC_W-1:0]    drain_cnt;
  logic               last_pixel;
  logic               active;
  logic [COORD_W:0]   sx;
  logic [COORD_W:0]   sy;
  logic               pix_en;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [RGB_W-1:0]   pix_rgb;

  assign last_pixel = (lx == LX_LAST) && (ly == LY_LAST);
  assign active     = (state != ST_IDLE);
  assign cmd.active = active;
  assign cmd.done   = (state == ST_DONE);
  assign sx = {1'b0, ox} + (COORD_W + 1)'(lx);
  assign sy = {1'b0, oy} + (COORD_W + 1)'(ly);

  // raster order makes base + ly*IMG_W + lx a plain increment of the address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      ox        <= '0;
      oy        <= '0;
      lx        <= '0;
      ly        <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd.draw) state <= ST_LOAD;
        ST_LOAD: begin
          rom_addr <= cmd.tile_address;
          ox       <= cmd.origin_x;
          oy       <= cmd.origin_y;
          lx       <= '0;
          ly       <= '0;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (last_pixel) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            if (lx == LX_LAST) begin
              lx <= '0;
              ly <= ly + 1'b1;
            end else begin
              lx <= lx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= ST_DONE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  blit_pixel_pipe #(
    .COORD_W(COORD_W), .RGB_W(RGB_W), .LATENCY(ROM_LATENCY),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .TRANSPARENT_EN(TRANSPARENT_EN), .KEY_RGB(KEY_RGB)
  ) u_pipe (
    .clk(clk),
    .reset(reset),
    .in_valid(state == ST_FETCH),
    .in_x(sx),
    .in_y(sy),
    .rom_data(cmd.rom_request_data),
    .draw_enable(pix_en),
    .x(pix_x),
    .y(pix_y),
    .rgb(pix_rgb)
  );

  assign rom_address_bus     = active ? rom_addr : 'z;
  assign vga_draw_enable_bus = active ? pix_en   : 1'bz;
  assign vga_x_out_bus       = active ? pix_x    : 'z;
  assign vga_y_out_bus       = active ? pix_y    : 'z;
  assign vga_RGB_out_bus     = active ? pix_rgb  : 'z;
endmodule

// File: tb/tb_tile_blitter.sv
// tb/tb_tile_blitter.sv - directed bench for tile_blitter (2x2 image, ROM latency 2)
module tb_tile_blitter;
  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        other_en = 1'b0;
  logic [15:0] key_addr = 16'hFFFF;
  logic [23:0] rom_d1, rom_d2;
  int checks = 0;
  int errors = 0;

  tri [15:0] rom_address_bus;
  tri        vga_draw_enable_bus;
  tri [7:0]  vga_x_out_bus;
  tri [7:0]  vga_y_out_bus;
  tri [23:0] vga_RGB_out_bus;

  tile_blitter_if bus_if ();

  always #5 clk = ~clk;

  // a second drawer sharing the buses
  assign rom_address_bus     = other_en ? 16'hA5A5 : 16'hzzzz;
  assign vga_draw_enable_bus = other_en ? 1'b1 : 1'bz;
  assign vga_x_out_bus       = other_en ? 8'h3C : 8'hzz;
  assign vga_y_out_bus       = other_en ? 8'hC3 : 8'hzz;
  assign vga_RGB_out_bus     = other_en ? 24'h5A5A5A : 24'hzzzzzz;

  function automatic logic [23:0] rom_word(input logic [15:0] a);
    return (a == key_addr) ? 24'hFF00FF : {8'h00, a};
  endfunction

  always @(posedge clk) begin
    rom_d1 <= rom_word(rom_address_bus);
    rom_d2 <= rom_d1;
  end
  assign bus_if.rom_request_data = rom_d2;

  tile_blitter #(
    .IMG_W(2), .IMG_H(2), .SCREEN_W(160), .SCREEN_H(120),
    .COORD_W(8), .ADDR_W(16), .RGB_W(24), .ROM_LATENCY(2),
    .TRANSPARENT_EN(1'b1), .KEY_RGB(24'hFF00FF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd(bus_if),
    .rom_address_bus(rom_address_bus),
    .vga_draw_enable_bus(vga_draw_enable_bus),
    .vga_x_out_bus(vga_x_out_bus),
    .vga_y_out_bus(vga_y_out_bus),
    .vga_RGB_out_bus(vga_RGB_out_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_foreign(input string tag);
    check({tag, " addr"}, rom_address_bus, 16'hA5A5);
    check({tag, " en"},   vga_draw_enable_bus, 1'b1);
    check({tag, " x"},    vga_x_out_bus, 8'h3C);
    check({tag, " y"},    vga_y_out_bus, 8'hC3);
    check({tag, " rgb"},  vga_RGB_out_bus, 24'h5A5A5A);
  endtask

  // cycle c lies between edge c-1 and edge c; draw is sampled at edge 0
  task automatic run_blit(input logic [15:0] base, input logic [7:0] ox, input logic [7:0] oy,
                          input logic [3:0] mask, input bit repulse, input bit hold);
    logic exp_act;
    int   k;
    @(negedge clk);
    bus_if.tile_address = base;
    bus_if.origin_x     = ox;
    bus_if.origin_y     = oy;
    bus_if.draw         = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      exp_act = (c <= 9) || (hold && c == 11);
      check($sformatf("active c%0d", c), bus_if.active, exp_act);
      check($sformatf("done c%0d", c), bus_if.done, (c == 9));
      if (c >= 2 && c <= 8) begin
        k = (c > 5) ? 3 : c - 2;
        check($sformatf("addr c%0d", c), rom_address_bus, base + 16'(k));
      end
      if (exp_act) begin
        if (c >= 5 && c <= 8) begin
          k = c - 5;
          check($sformatf("strobe px%0d", k), vga_draw_enable_bus, mask[k]);
          if (mask[k]) begin
            check($sformatf("x px%0d", k), vga_x_out_bus, 8'(ox + 8'(k % 2)));
            check($sformatf("y px%0d", k), vga_y_out_bus, 8'(oy + 8'(k / 2)));
            check($sformatf("rgb px%0d", k), vga_RGB_out_bus, {8'h00, 16'(base + 16'(k))});
          end
        end else begin
          check($sformatf("no strobe c%0d", c), vga_draw_enable_bus, 1'b0);
        end
      end
      if (c == 2 && !hold) begin
        bus_if.draw         = 1'b0;
        bus_if.tile_address = 16'hDEAD;
        bus_if.origin_x     = 8'h77;
        bus_if.origin_y     = 8'h33;
      end
      if (repulse && c == 3) bus_if.draw = 1'b1;
      if (repulse && c == 4) bus_if.draw = 1'b0;
    end
    if (hold) begin
      bus_if.draw = 1'b0;
      for (int c = 12; c <= 21; c++) begin
        @(negedge clk);
        check($sformatf("run2 active c%0d", c), bus_if.active, (c <= 19));
        check($sformatf("run2 done c%0d", c), bus_if.done, (c == 19));
        if (c >= 12 && c <= 15)
          check($sformatf("run2 addr c%0d", c), rom_address_bus, base + 16'(c - 12));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    bus_if.draw         = 1'b0;
    bus_if.tile_address = '0;
    bus_if.origin_x     = '0;
    bus_if.origin_y     = '0;

    repeat (2) @(negedge clk);
    check("reset active", bus_if.active, 1'b0);
    check("reset done", bus_if.done, 1'b0);
    other_en = 1'b1;
    #1;
    check_foreign("reset bus");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle active", bus_if.active, 1'b0);
    check_foreign("idle bus");
    other_en = 1'b0;

    run_blit(16'h0100, 8'd10, 8'd20, 4'b1111, 1'b0, 1'b0);
    run_blit(16'h0010, 8'd159, 8'd119, 4'b0001, 1'b0, 1'b0);
    key_addr = 16'h0201;
    run_blit(16'h0200, 8'd30, 8'd40, 4'b1101, 1'b0, 1'b0);
    key_addr = 16'hFFFF;
    run_blit(16'h0300, 8'd0, 8'd0, 4'b1111, 1'b1, 1'b0);
    run_blit(16'h0380, 8'd1, 8'd2, 4'b1111, 1'b0, 1'b1);

    @(negedge clk);
    bus_if.tile_address = 16'h0400;
    bus_if.origin_x     = 8'd5;
    bus_if.origin_y     = 8'd5;
    bus_if.draw         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.draw = 1'b0;
    repeat (2) @(negedge clk);
    check("rst pre active", bus_if.active, 1'b1);
    check("rst pre addr", rom_address_bus, 16'h0401);
    reset = 1'b1;
    #1;
    check("rst active", bus_if.active, 1'b0);
    check("rst done", bus_if.done, 1'b0);
    other_en = 1'b1;
    #1;
    check_foreign("rst bus");
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus_if.done | bus_if.active;
    end
    check("rst no done", seen, 1'b0);
    check_foreign("post rst bus");
    other_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
